// File: rtl/mmio_bridge_if.sv
// CPU-side memory port and RAM-side port of the MMIO bridge, grouped as one bus.
// The bridge uses the slave view. The CPU and RAM side (or a bench) uses the master view.
interface mmio_bridge_if;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  modport slave (
    input  cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_rdata_i,
    output cpu_rdata_o, ram_we_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output cpu_we_i, cpu_addr_i, cpu_wdata_i, ram_rdata_i,
    input  cpu_rdata_o, ram_we_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO bridge: passes RAM accesses (addr[31]=0) straight through and decodes
// a small peripheral page holding an 8N1 UART transmitter with a byte FIFO
// and a free-running 32-bit timer with a sticky compare flag.
module mmio_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mmio_bridge_if.slave  bus,
  output logic          uart_tx_o,
  output logic          timer_irq_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0] ADDR_DATA   = 32'h8000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
  localparam logic [31:0] ADDR_COUNT  = 32'h8000_0008;
  localparam logic [31:0] ADDR_CMP    = 32'h8000_000C;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW:0]   wr_ptr_q, rd_ptr_q;
  logic          ovf_q;
  logic [31:0]   count_q, cmp_q;
  logic          irq_q;

  logic periph, wr_data, wr_status, wr_count, wr_cmp;
  logic fifo_empty, fifo_full, baud_done, pop, push_ok;
  logic [31:0] rdata_d;

  // Address decode
  assign periph    = bus.cpu_addr_i[31];
  assign wr_data   = bus.cpu_we_i && (bus.cpu_addr_i == ADDR_DATA);
  assign wr_status = bus.cpu_we_i && (bus.cpu_addr_i == ADDR_STATUS);
  assign wr_count  = bus.cpu_we_i && (bus.cpu_addr_i == ADDR_COUNT);
  assign wr_cmp    = bus.cpu_we_i && (bus.cpu_addr_i == ADDR_CMP);

  // RAM passthrough, zero latency
  assign bus.ram_addr_o  = bus.cpu_addr_i;
  assign bus.ram_wdata_o = bus.cpu_wdata_i;
  assign bus.ram_we_o    = bus.cpu_we_i & ~periph;

  // FIFO flags: the extra pointer MSB tells full from empty
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign baud_done  = (baud_q == BAUD_LAST);
  // Pop from IDLE, or at the very end of STOP so frames run back to back
  assign pop        = !fifo_empty &&
                      ((state_q == IDLE) || ((state_q == STOP) && baud_done));
  // A pop in the same cycle frees a slot, so a push while full still lands
  assign push_ok    = wr_data && (!fifo_full || pop);

  // FIFO pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

  // FIFO storage (contents are don't-care until the pointers say otherwise)
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[PW-1:0]] <= bus.cpu_wdata_i[7:0];
  end

  // Sticky overflow flag: set on a dropped byte, cleared by STATUS bit3 write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                ovf_q <= 1'b0;
    else if (wr_data && fifo_full && !pop)     ovf_q <= 1'b1;
    else if (wr_status && bus.cpu_wdata_i[3])  ovf_q <= 1'b0;
  end

  // Shift register: loaded on pop, shifted at the end of each data bit
  always_ff @(posedge clk) begin
    if (pop)                                shift_q <= fifo_mem[rd_ptr_q[PW-1:0]];
    else if ((state_q == DATA) && baud_done) shift_q <= {1'b0, shift_q[7:1]};
  end

  // TX FSM with registered line output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (pop) begin
            state_q <= START;
            bit_q   <= '0;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q <= bit_q + 3'd1;
              tx_q  <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              state_q <= START;
              bit_q   <= '0;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
      endcase
    end
  end

  // Timer: write beats increment; compare write clears irq and beats a match
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      cmp_q   <= 32'hFFFF_FFFF;
      irq_q   <= 1'b0;
    end else begin
      count_q <= wr_count ? bus.cpu_wdata_i : count_q + 32'd1;
      if (wr_cmp) begin
        cmp_q <= bus.cpu_wdata_i;
        irq_q <= 1'b0;
      end else if (count_q == cmp_q) begin
        irq_q <= 1'b1;
      end
    end
  end

  // Load data mux, combinational from current state
  always_comb begin
    rdata_d = '0;
    if (!periph)                               rdata_d = bus.ram_rdata_i;
    else if (bus.cpu_addr_i == ADDR_STATUS)    rdata_d = {27'd0, irq_q, ovf_q,
                                                          state_q != IDLE,
                                                          fifo_empty, fifo_full};
    else if (bus.cpu_addr_i == ADDR_COUNT)     rdata_d = count_q;
    else if (bus.cpu_addr_i == ADDR_CMP)       rdata_d = cmp_q;
  end

  assign bus.cpu_rdata_o = rdata_d;
  assign uart_tx_o       = tx_q;
  assign timer_irq_o     = irq_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Bench for mmio_bridge: directed steps plus a randomized phase, checked
// every cycle against a timeline-based reference model of the bridge.
module tb_mmio_bridge;
  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] A_DATA   = 32'h8000_0000;
  localparam logic [31:0] A_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_COUNT  = 32'h8000_0008;
  localparam logic [31:0] A_CMP    = 32'h8000_000C;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic uart_tx_o, timer_irq_o;
  always #5 clk = ~clk;

  mmio_bridge_if bus();

  mmio_bridge #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .uart_tx_o(uart_tx_o), .timer_irq_o(timer_irq_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: bytes waiting, the frame on the wire (by start edge), timer
  logic [7:0]  m_q[$];
  bit          m_ovf, m_irq, m_have;
  logic [31:0] m_count, m_cmp;
  logic [7:0]  m_byte;
  int          m_start, m_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return m_have && (m_n >= m_start) && (m_n < m_start + 10*C);
  endfunction

  function automatic logic m_line();
    int idx;
    if (!m_busy()) return 1'b1;
    idx = (m_n - m_start) / C;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return m_byte[idx-1];
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] addr);
    if (!addr[31])         return bus.ram_rdata_i;
    if (addr == A_STATUS)  return {27'd0, m_irq, m_ovf, m_busy(),
                                   m_q.size() == 0, m_q.size() == D};
    if (addr == A_COUNT)   return m_count;
    if (addr == A_CMP)     return m_cmp;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_irq = 0; m_have = 0;
    m_count = 32'd0; m_cmp = 32'hFFFF_FFFF;
    m_byte = 8'd0; m_start = 0; m_n = 0;
  endtask

  // Advance the model across one rising edge using the currently driven inputs
  task automatic model_edge();
    int k;
    logic [31:0] c_pre, m_pre;
    logic we;
    logic [31:0] a, w;
    we = bus.cpu_we_i; a = bus.cpu_addr_i; w = bus.cpu_wdata_i;
    k = m_n + 1;
    if (m_q.size() > 0 && (!m_have || k >= m_start + 10*C)) begin
      m_have = 1; m_start = k; m_byte = m_q.pop_front();
    end
    if (we && a == A_DATA) begin
      if (m_q.size() < D) m_q.push_back(w[7:0]);
      else m_ovf = 1;
    end
    if (we && a == A_STATUS && w[3]) m_ovf = 0;
    c_pre = m_count; m_pre = m_cmp;
    m_count = (we && a == A_COUNT) ? w : c_pre + 32'd1;
    if (we && a == A_CMP) begin
      m_irq = 0; m_cmp = w;
    end else if (c_pre == m_pre) begin
      m_irq = 1;
    end
    m_n = k;
  endtask

  // Called at a falling edge with inputs already driven
  task automatic tick();
    #1;
    chk("ram_we",    {31'd0, bus.ram_we_o}, {31'd0, bus.cpu_we_i & ~bus.cpu_addr_i[31]});
    chk("ram_addr",  bus.ram_addr_o, bus.cpu_addr_i);
    chk("ram_wdata", bus.ram_wdata_o, bus.cpu_wdata_i);
    chk("rdata",     bus.cpu_rdata_o, m_rdata(bus.cpu_addr_i));
    model_edge();
    @(posedge clk);
    @(negedge clk);
    chk("uart_tx", {31'd0, uart_tx_o}, {31'd0, m_line()});
    chk("irq",     {31'd0, timer_irq_o}, {31'd0, m_irq});
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_wdata_i = wdata;
  endtask

  initial begin
    logic [31:0] r;
    bit found;
    drive(0, 32'd0, 32'd0);
    bus.ram_rdata_i = 32'd0;
    model_reset();

    // Reset held, then released
    repeat (2) begin
      @(negedge clk);
      chk("rst_tx",  {31'd0, uart_tx_o}, 32'd1);
      chk("rst_irq", {31'd0, timer_irq_o}, 32'd0);
    end
    reset = 1'b1;
    drive(0, A_STATUS, 32'd0);
    tick();
    drive(0, A_COUNT, 32'd0);
    repeat (5) tick();

    // RAM passthrough
    drive(1, 32'h0000_0040, 32'h1234_5678);
    tick();
    drive(0, 32'h0000_0040, 32'd0);
    bus.ram_rdata_i = 32'hDEAD_BEEF;
    tick();
    bus.ram_rdata_i = 32'd0;

    // Single frame of 0x55, watching STATUS throughout
    drive(1, A_DATA, 32'h0000_0055);
    tick();
    drive(0, A_STATUS, 32'd0);
    repeat (45) tick();

    // Six back-to-back bytes: five accepted, sixth overflows
    for (int i = 0; i < 6; i++) begin
      drive(1, A_DATA, $urandom() & 32'hFF);
      tick();
    end
    drive(0, A_STATUS, 32'd0);
    repeat (5*10*C + 5) tick();
    drive(1, A_STATUS, 32'h8);
    tick();
    drive(0, A_STATUS, 32'd0);
    tick();

    // Timer compare, sticky through wrap, cleared by compare write
    drive(1, A_CMP, 32'd20);   tick();
    drive(1, A_COUNT, 32'd10); tick();
    drive(0, A_STATUS, 32'd0);
    repeat (15) tick();
    drive(1, A_COUNT, 32'hFFFF_FFF0); tick();
    drive(0, A_COUNT, 32'd0);
    repeat (25) tick();
    drive(1, A_CMP, 32'd5); tick();
    drive(0, A_CMP, 32'd0);
    repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          r = $urandom() & 32'h7FFF_FFFF;
          bus.ram_rdata_i = $urandom();
          drive($urandom_range(0, 1), r, $urandom());
        end
        3: drive(1, A_DATA, $urandom());
        4: drive($urandom_range(0, 1), A_STATUS, $urandom());
        5: drive(1, A_CMP, m_count + $urandom_range(3, 30));
        6: drive(($urandom_range(0, 3) == 0), A_COUNT, $urandom());
        default: drive(0, 32'h8000_0000 + 32'($urandom_range(0, 20)), 32'd0);
      endcase
      tick();
    end

    // Mid-frame reset: queue three bytes, reset during data bit 3 of the first
    drive(0, A_STATUS, 32'd0);
    repeat (12*C) tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, A_DATA, 32'hA3 + 32'(i));
      tick();
    end
    drive(0, A_STATUS, 32'd0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_have && m_n == m_start + 4*C + 1) found = 1;
      else tick();
    end
    chk("reach_bit3", {31'd0, found}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_tx",  {31'd0, uart_tx_o}, 32'd1);
    chk("midrst_irq", {31'd0, timer_irq_o}, 32'd0);
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_hold_tx", {31'd0, uart_tx_o}, 32'd1);
    end
    reset = 1'b1;
    drive(0, A_STATUS, 32'd0);
    repeat (50) tick();

    // Unmapped read and write
    drive(0, 32'h8000_0010, 32'd0);
    tick();
    drive(1, 32'h8000_0010, 32'hFFFF_FFFF);
    tick();
    drive(0, A_STATUS, 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits directly downstream of the cpu memory port (we_o/addr_o/data_o/data_i) and is the only block the cpu talks to for loads and stores.
- Decodes each access to either external RAM (passthrough) or on-chip peripherals: a UART transmitter with a byte FIFO, and a 32-bit timer with compare interrupt.
- Gives the core console output and a time base without changing its memory interface.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit (>=2)
FIFO_DEPTH, 4, UART TX FIFO entries (power of two, >=2)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-low reset (0 = reset asserted)
cpu_we_i  input  1  write strobe from cpu
cpu_addr_i  input  32  access address from cpu
cpu_wdata_i  input  32  store data from cpu
cpu_rdata_o  output  32  load data to cpu, combinational
ram_we_o  output  1  RAM write strobe
ram_addr_o  output  32  RAM address
ram_wdata_o  output  32  RAM write data
ram_rdata_i  input  32  RAM read data
uart_tx_o  output  1  serial out, 8N1, idle high
timer_irq_o  output  1  sticky timer compare flag

Behaviour:
- Address map:
  - addr[31]=0: RAM.
  - 0x8000_0000: UART DATA (write only).
  - 0x8000_0004: STATUS.
  - 0x8000_0008: TIMER COUNT.
  - 0x8000_000C: TIMER COMPARE.
  - Any other addr[31]=1: unmapped. Reads return 0; writes are ignored.
- RAM region:
  - ram_addr_o = cpu_addr_i and ram_wdata_o = cpu_wdata_i, unconditionally.
  - ram_we_o = cpu_we_i & ~addr[31].
  - cpu_rdata_o = ram_rdata_i.
  - Zero added latency.
- Peripheral access timing:
  - Reads are combinational from current register state.
  - Writes commit on the rising edge where cpu_we_i=1.
  - ram_we_o=0 for all peripheral addresses.
- Reset values (reset=0, immediate, async):
  - uart_tx_o=1, FIFO empty, TX FSM IDLE.
  - count=0, compare=0xFFFF_FFFF.
  - timer_irq_o=0, overflow flag=0.
  - cpu_rdata_o follows decode.
  - Reset asserted mid-frame aborts the frame: line high next, FIFO contents discarded.
- STATUS read:
  - bit0 = FIFO full.
  - bit1 = FIFO empty.
  - bit2 = TX busy (FSM not IDLE).
  - bit3 = overflow (sticky).
  - bit4 = timer_irq_o.
  - Other bits 0.
- STATUS write: wdata[3]=1 clears overflow. Other bits ignored.
- UART DATA write:
  - Pushes wdata[7:0] into the FIFO.
  - If the FIFO is full, the byte is dropped and overflow is set.
  - A push while full, in the same cycle the FSM pops, is accepted: the pop frees a slot first.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: when FIFO is non-empty, pop the head into a shift register and go to START on the next edge.
  - START: drive 0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: drive 1 for CLKS_PER_BIT cycles.
  - From STOP, with FIFO non-empty: go directly to START with the next byte. No extra idle cycle, so back-to-back frames are exactly 10*CLKS_PER_BIT apart.
  - uart_tx_o is registered.
- Timer COUNT:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF -> 0.
  - A write loads wdata; the write has priority over the increment that cycle.
- Timer irq:
  - Set on the edge after count == compare.
  - Stays set (sticky) through wrap.
  - Cleared by any write to COMPARE. The new compare takes effect on the same edge.
  - If clear and match coincide, clear wins; a match with the new value is evaluated from the next cycle.
- Widths: FIFO pointers log2(FIFO_DEPTH)+1 bits for full/empty distinction. The bit counter and baud counter are sized for 8 and CLKS_PER_BIT-1.

Test Plan:
- Reset checks:
  - Hold reset=0, then release.
  - Required: uart_tx_o=1, STATUS read = 0x2, COUNT read 0 then incrementing by 1 per cycle, timer_irq_o=0.
- RAM passthrough:
  - Write 0x1234_5678 to 0x0000_0040.
  - Required: ram_we_o=1 for exactly that cycle, ram_addr_o=0x40, ram_wdata_o=0x1234_5678.
  - Drive ram_rdata_i=0xDEAD_BEEF on a read of 0x40. Required: cpu_rdata_o=0xDEAD_BEEF in the same cycle.
- Single UART frame:
  - CLKS_PER_BIT=4, write 0x55 to DATA.
  - Required: line reads start(0) then 1,0,1,0,1,0,1,0 then stop(1), each held 4 cycles, 40 cycles total.
  - STATUS bit2=1 during the frame and 0 after.
- FIFO overflow:
  - Write 6 bytes back-to-back (FIFO_DEPTH=4, first byte popped immediately).
  - Required: 5 accepted, 6th dropped, STATUS bit3=1, 5 frames transmitted contiguously.
  - Write STATUS 0x8. Required: bit3=0.
- Timer compare:
  - Write COMPARE=20, then COUNT=10.
  - Required: timer_irq_o rises on the edge after count==20 and stays high after wrap.
  - Write COMPARE=5. Required: irq=0 on the next edge.
- Mid-frame reset and unmapped access:
  - Assert reset during DATA bit 3. Required: uart_tx_o=1 immediately, FIFO empty after release.
  - Read 0x8000_0010. Required: 0.
  - Write to 0x8000_0010. Required: ram_we_o stays 0.
